// File: rtl/token_printer.sv
// token_printer: converts 16-bit lexer tokens {KIND[15:8], VALUE[7:0]} back
// into ASCII text, one byte per output handshake. Each token is followed by
// a separator byte. After the EOF token, a terminator byte is emitted and the
// printer parks in DONE until reset.
//
// Ports:
//   CLK, RST          clock; synchronous active-high reset
//   I_VALID/I_READY   token input handshake (I_READY is a state decode)
//   I_DATA[15:0]      token {KIND, VALUE}
//   O_VALID/O_READY   byte output handshake
//   O_DATA[7:0]       ASCII byte
//   BUSY              token text, separator or terminator in flight
//   DONE              EOF fully emitted; sticky until RST
module token_printer #(
  parameter logic [7:0] SEP_CHAR  = 8'h20,
  parameter logic [7:0] EOL_CHAR  = 8'h0a,
  parameter logic [7:0] TERM_CHAR = 8'h00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_VALID,
  output logic        I_READY,
  input  logic [15:0] I_DATA,
  output logic        O_VALID,
  input  logic        O_READY,
  output logic [7:0]  O_DATA,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {S_IDLE, S_EMIT, S_SEP, S_TERM, S_DONE} state_t;

  state_t     r_state, w_next;
  logic [7:0] r_buf0, r_buf1, r_buf2;
  logic [1:0] r_len, r_idx;
  logic       r_semi, r_eof;

  logic       w_accept;
  logic       w_last;
  logic [7:0] w_t0, w_t1, w_t2;
  logic [1:0] w_len;
  logic [7:0] w_val, w_rem;
  logic [1:0] w_hund;
  logic [3:0] w_tens, w_ones;

  assign w_val    = I_DATA[7:0];
  assign w_accept = (r_state == S_IDLE) && I_VALID && !RST;
  assign w_last   = (r_idx == r_len - 2'd1);

  // Decimal split by compare ladders (no divider): hundreds, then tens.
  always_comb begin
    w_hund = 2'd0;
    w_rem  = w_val;
    if (w_val >= 8'd200) begin
      w_hund = 2'd2;
      w_rem  = w_val - 8'd200;
    end else if (w_val >= 8'd100) begin
      w_hund = 2'd1;
      w_rem  = w_val - 8'd100;
    end
    w_tens = 4'd0;
    for (int unsigned t = 1; t < 10; t++) begin
      if (w_rem >= 8'(t * 10)) w_tens = 4'(t);
    end
    w_ones = 4'(w_rem - 8'(w_tens) * 8'd10);
  end

  // Token text decode, done entirely in the accept cycle.
  always_comb begin
    w_t0  = 8'h3f;  // '?'
    w_t1  = 8'h00;
    w_t2  = 8'h00;
    w_len = 2'd1;
    case (I_DATA[15:8])
      8'h00: w_t0 = 8'h3b;                                                 // ;
      8'h01: begin w_t0 = 8'h6f; w_t1 = 8'h75; w_t2 = 8'h74; w_len = 2'd3; end // out
      8'h02: w_t0 = w_val;
      8'h03: w_t0 = 8'h3d;                                                 // =
      8'h04: begin w_t0 = 8'h69; w_t1 = 8'h66; w_len = 2'd2; end           // if
      8'h05: w_t0 = 8'h28;                                                 // (
      8'h06: w_t0 = 8'h29;                                                 // )
      8'h07: begin w_t0 = 8'h3c; w_t1 = 8'h3c; w_len = 2'd2; end           // <<
      8'h08: begin w_t0 = 8'h3e; w_t1 = 8'h3e; w_len = 2'd2; end           // >>
      8'h09: w_t0 = 8'h2b;                                                 // +
      8'h0a: w_t0 = 8'h2d;                                                 // -
      8'h0b: begin
        if (w_val == 8'hff) begin
          w_t0 = 8'h3f;
        end else if (w_hund != 2'd0) begin
          w_t0  = 8'h30 + {6'd0, w_hund};
          w_t1  = 8'h30 + {4'd0, w_tens};
          w_t2  = 8'h30 + {4'd0, w_ones};
          w_len = 2'd3;
        end else if (w_tens != 4'd0) begin
          w_t0  = 8'h30 + {4'd0, w_tens};
          w_t1  = 8'h30 + {4'd0, w_ones};
          w_len = 2'd2;
        end else begin
          w_t0 = 8'h30 + {4'd0, w_ones};
        end
      end
      8'h0c: begin w_t0 = 8'h45; w_t1 = 8'h4f; w_t2 = 8'h46; w_len = 2'd3; end // EOF
      default: ;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    I_READY = 1'b0;
    O_VALID = 1'b0;
    O_DATA  = '0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (r_state)
      S_IDLE: begin
        I_READY = !RST;
        if (w_accept) w_next = S_EMIT;
      end
      S_EMIT: begin
        O_VALID = 1'b1;
        BUSY    = 1'b1;
        O_DATA  = (r_idx == 2'd0) ? r_buf0 : (r_idx == 2'd1) ? r_buf1 : r_buf2;
        if (O_READY && w_last) w_next = S_SEP;
      end
      S_SEP: begin
        O_VALID = 1'b1;
        BUSY    = 1'b1;
        O_DATA  = r_semi ? EOL_CHAR : SEP_CHAR;
        if (O_READY) w_next = r_eof ? S_TERM : S_IDLE;
      end
      S_TERM: begin
        O_VALID = 1'b1;
        BUSY    = 1'b1;
        O_DATA  = TERM_CHAR;
        if (O_READY) w_next = S_DONE;
      end
      S_DONE: DONE = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_len   <= 2'd1;
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_buf2  <= '0;
      r_semi  <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_buf0 <= w_t0;
        r_buf1 <= w_t1;
        r_buf2 <= w_t2;
        r_len  <= w_len;
        r_idx  <= '0;
        r_semi <= (I_DATA[15:8] == 8'h00);
        r_eof  <= (I_DATA[15:8] == 8'h0c);
      end else if (r_state == S_EMIT && O_READY && !w_last) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_token_printer.sv
module tb_token_printer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        I_VALID;
  logic        I_READY;
  logic [15:0] I_DATA;
  logic        O_VALID;
  logic        O_READY;
  logic [7:0]  O_DATA;
  logic        BUSY;
  logic        DONE;

  token_printer #(.SEP_CHAR(8'h20), .EOL_CHAR(8'h0a), .TERM_CHAR(8'h00)) dut (
    .CLK(CLK), .RST(RST),
    .I_VALID(I_VALID), .I_READY(I_READY), .I_DATA(I_DATA),
    .O_VALID(O_VALID), .O_READY(O_READY), .O_DATA(O_DATA),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] tok;
    logic [39:0] exp;  // expected bytes, left-aligned
    int          n;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sends a token with O_READY held high; bytes must come out back-to-back.
  task automatic send(input logic [15:0] tok, input logic [39:0] exp, input int n);
    int w;
    w = 0;
    I_DATA  = tok;
    I_VALID = 1'b1;
    while (!I_READY && w < 20) begin
      tick();
      w++;
    end
    check("accept_ready", 32'(I_READY), 32'd1);
    tick();
    I_VALID = 1'b0;
    for (int k = 0; k < n; k++) begin
      check($sformatf("byte_%04h_%0d", tok, k), 32'({O_VALID, O_DATA}),
            32'({1'b1, exp[39 - 8*k -: 8]}));
      tick();
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] held;
    logic       stalled;
    int         got;
    logic [23:0] bp_exp;

    vecs = '{
      '{16'h0100, 40'h6f75742000, 4},  // out
      '{16'h0261, 40'h6120000000, 2},  // a
      '{16'h0300, 40'h3d20000000, 2},  // =
      '{16'h0b2a, 40'h3432200000, 3},  // 42
      '{16'h0000, 40'h3b0a000000, 2},  // ;
      '{16'h0b00, 40'h3020000000, 2},  // 0
      '{16'h0b09, 40'h3920000000, 2},  // 9
      '{16'h0b0a, 40'h3130200000, 3},  // 10
      '{16'h0b63, 40'h3939200000, 3},  // 99
      '{16'h0b64, 40'h3130302000, 4},  // 100
      '{16'h0bc8, 40'h3230302000, 4},  // 200
      '{16'h0bfe, 40'h3235342000, 4},  // 254
      '{16'h0bff, 40'h3f20000000, 2},  // NUM ff -> ?
      '{16'h0d55, 40'h3f20000000, 2},  // unknown kind
      '{16'hffff, 40'h3f20000000, 2},  // unknown kind
      '{16'h0400, 40'h6966200000, 3},  // if
      '{16'h0500, 40'h2820000000, 2},
      '{16'h0600, 40'h2920000000, 2},
      '{16'h0800, 40'h3e3e200000, 3},
      '{16'h0a00, 40'h2d20000000, 2},
      '{16'h0900, 40'h2b20000000, 2},
      '{16'h0900, 40'h2b20000000, 2},  // repeat, no de-dup
      '{16'h0c00, 40'h454f462000, 5}   // EOF + sep + term
    };

    RST = 1'b1; I_VALID = 1'b0; I_DATA = '0; O_READY = 1'b1;
    tick();
    tick();
    check("rst_o_valid", 32'(O_VALID), 32'd0);
    check("rst_o_data",  32'(O_DATA),  32'd0);
    check("rst_busy",    32'(BUSY),    32'd0);
    check("rst_done",    32'(DONE),    32'd0);
    check("rst_i_ready", 32'(I_READY), 32'd0);
    RST = 1'b0;
    #1;
    check("idle_i_ready", 32'(I_READY), 32'd1);

    // Backpressure on "<<": O_READY toggles 1,0,1,0...
    bp_exp = 24'h3c3c20;
    O_READY = 1'b0;
    I_DATA = 16'h0700; I_VALID = 1'b1;
    tick();
    I_VALID = 1'b0;
    got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      check("bp_valid", 32'(O_VALID), 32'd1);
      check("bp_i_ready", 32'(I_READY), 32'd0);
      if (stalled) check("bp_hold", 32'(O_DATA), 32'(held));
      O_READY = (cyc % 2 == 0);
      held = O_DATA;
      tick();
      if (O_READY) begin
        check($sformatf("bp_byte_%0d", got), 32'(held), 32'(bp_exp[23 - 8*got -: 8]));
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
    end
    check("bp_count", 32'(got), 32'd3);
    check("bp_after_ready", 32'(I_READY), 32'd1);
    O_READY = 1'b1;

    // Reset in the middle of "out" after its first byte.
    I_DATA = 16'h0100; I_VALID = 1'b1;
    tick();
    I_VALID = 1'b0;
    check("mid_first", 32'(O_DATA), 32'h6f);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check("mid_o_valid", 32'(O_VALID), 32'd0);
    check("mid_busy",    32'(BUSY),    32'd0);
    check("mid_i_ready", 32'(I_READY), 32'd1);
    send(16'h0900, 40'h2b20000000, 2);

    foreach (vecs[i]) send(vecs[i].tok, vecs[i].exp, vecs[i].n);
    check("eof_done", 32'(DONE), 32'd1);
    check("eof_busy", 32'(BUSY), 32'd0);

    // Tokens after DONE are never accepted.
    I_DATA = 16'h0100; I_VALID = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("done_i_ready", 32'(I_READY), 32'd0);
      check("done_o_valid", 32'(O_VALID), 32'd0);
      tick();
    end
    check("done_sticky", 32'(DONE), 32'd1);
    I_VALID = 1'b0;

    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check("rearm_done", 32'(DONE), 32'd0);
    send(16'h0100, 40'h6f75742000, 4);
    check("rearm_done_after", 32'(DONE), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/token_printer.md
Name: token_printer

Overview:
- Inverse of the lexer: takes 16-bit tokens {KIND[15:8], VALUE[7:0]} and emits their ASCII text one byte at a time, each token followed by a separator.
- Used for round-trip lexer checks (source -> lexer -> token_printer -> bytes compared with the normalised source) and for echoing token streams to the debug UART byte path.
- Valid/ready on both sides. Stops after EOF.

Parameters:
- SEP_CHAR, 8'h20, separator byte after every token except SEMICOLON.
- EOL_CHAR, 8'h0a, separator byte after SEMICOLON.
- TERM_CHAR, 8'h00, terminator byte emitted after the EOF token's separator.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- I_VALID  in  1  token available
- I_READY  out  1  printer can accept a token this cycle
- I_DATA  in  16  token {KIND, VALUE}
- O_VALID  out  1  byte available
- O_READY  in  1  downstream accepts byte
- O_DATA  out  8  ASCII byte
- BUSY  out  1  a token is being emitted (state is not IDLE or DONE)
- DONE  out  1  EOF fully emitted; sticky until RST

Behaviour:
- Reset: state IDLE. O_VALID=0, O_DATA=0, BUSY=0, DONE=0. I_READY=0 during the RST cycle.
- I_READY = (state==IDLE). It is a decode of registered state with no combinational path from O_READY.
- A token is accepted when I_VALID && I_READY. The token text is loaded into buffer buf[0..2] with length len (1..3), and idx is set to 0.
- O_VALID rises on the cycle after acceptance.
- KIND decoding (text, length):
  - 00 ";" (1)
  - 01 "out" (3)
  - 02 VALUE byte verbatim (1)
  - 03 "=" (1)
  - 04 "if" (2)
  - 05 "(" (1)
  - 06 ")" (1)
  - 07 "<<" (2)
  - 08 ">>" (2)
  - 09 "+" (1)
  - 0a "-" (1)
  - 0b decimal of VALUE (1-3)
  - 0c "EOF" (3)
  - any other KIND: "?" (1)
- NUM formatting:
  - VALUE 0..254 is printed in decimal with no leading zeros. "0" is 1 char, "254" is 3 chars.
  - VALUE 8'hff is printed as "?".
  - Digit split: hundreds = 2 if VALUE>=200, else 1 if VALUE>=100, else 0. The remainder is split into tens/ones with the same compare ladder. All decoding is done at accept time in one cycle.
- States:
  - IDLE: I_READY=1, O_VALID=0. On accept -> EMIT.
  - EMIT: O_VALID=1, O_DATA=buf[idx].
    - On O_READY with idx<len-1: idx+1.
    - On O_READY with idx==len-1: -> SEP.
  - SEP: O_VALID=1, O_DATA = EOL_CHAR if the token was SEMICOLON, else SEP_CHAR.
    - On O_READY: -> TERM if the token was EOF, else IDLE.
  - TERM: O_VALID=1, O_DATA=TERM_CHAR. On O_READY -> DONE.
  - DONE: I_READY=0, O_VALID=0, DONE=1. Stays here until RST. Further tokens are never accepted.
- Backpressure:
  - While O_VALID && !O_READY, O_DATA and state hold.
  - O_VALID never drops without a handshake, except on RST.
- Throughput:
  - One byte per cycle under continuous O_READY.
  - A token of length L occupies L+1 output cycles plus 1 IDLE cycle, so the next token is accepted in the IDLE cycle after the separator handshake.
- Reset mid-token: state returns to IDLE at once, O_VALID=0, and partial text is discarded.
- Repeated identical tokens are all printed; there is no de-duplication.

Test Plan:
- Stream {01,00},{02,61},{03,00},{0b,2a},{00,00},{0c,00} with O_READY=1 -> bytes 6f 75 74 20 61 20 3d 20 34 32 20 3b 0a 45 4f 46 20 00. DONE=1 after the 00 handshake.
- NUM boundaries {0b,00},{0b,09},{0b,0a},{0b,63},{0b,64},{0b,c8},{0b,fe},{0b,ff} -> "0","9","10","99","100","200","254","?", each followed by 20.
- Backpressure: token {07,00} with O_READY toggling 1010… -> output is 3c 3c 20. O_DATA is stable on every stalled cycle, and I_READY stays 0 until the 20 is accepted.
- Unknown KIND {0d,55} and {ff,ff} -> 3f 20 for each.
- After DONE, assert I_VALID with {01,00} for 10 cycles -> I_READY=0 and O_VALID=0. Then pulse RST and resend -> "out " is printed and DONE=0.
- RST asserted while in EMIT of "out" after the first byte -> next cycle O_VALID=0, BUSY=0, I_READY=1. The next token is printed from its first byte.
